// File: rtl/uart_pkg.sv
// Shared types and parity helpers for the UART transmit serializer.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_EVEN  = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   function automatic logic parity_en(parity_e t);
      return (t == PAR_ODD) || (t == PAR_EVEN);
   endfunction

   // xor_red is the even-parity bit (^data); odd parity is its complement.
   function automatic logic parity_bit(logic xor_red, parity_e t);
      return (t == PAR_ODD) ? ~xor_red : xor_red;
   endfunction

endpackage

// File: rtl/uart_piso_tx_if.sv
// Register-block side of the UART transmitter: write port, config, status and serial line.
interface uart_piso_tx_if #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 4
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                 send;
   logic [1:0]           parity_type;
   logic                 stop_bits;
   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   logic                 overflow;
   logic                 data_tx;
   logic                 active_flag;
   logic                 done_flag;

   modport master (
      output send, parity_type, stop_bits, wr_en, wr_data,
      input  fifo_full, fifo_empty, fifo_count, overflow, data_tx, active_flag, done_flag
   );

   modport slave (
      input  send, parity_type, stop_bits, wr_en, wr_data,
      output fifo_full, fifo_empty, fifo_count, overflow, data_tx, active_flag, done_flag
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with registered count/full/empty and a dropped-write pulse.
module uart_tx_fifo #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_BITS-1:0]          wdata,
   output logic [DATA_BITS-1:0]          rdata,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 full_q, empty_q, overflow_q;
   logic                 accept, do_pop;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_pop = pop && !empty_q;
   assign accept = push && (!full_q || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({accept, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= (count_d == CNT_W'(FIFO_DEPTH));
         empty_q    <= (count_d == '0);
         overflow_q <= push && full_q && !do_pop;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata    = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/uart_piso_tx.sv
// UART transmit serializer: FIFO-fed frame FSM shifting start/data/parity/stop bits LSB-first.
module uart_piso_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input logic           baud_clk,
   input logic           reset_n,
   uart_piso_tx_if.slave bus
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_cnt_q, stop_cnt_d;
   parity_e              par_type_q, par_type_d;
   logic                 stop2_q, stop2_d;
   logic                 par_bit_q, par_bit_d;
   logic                 done_q, done_d;

   logic                 fifo_pop;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 bit_end, can_load, load;
   logic                 tx_bit;
   parity_e              cfg_parity;

   uart_tx_fifo #(
      .DATA_BITS (DATA_BITS),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (baud_clk),
      .rst_n   (reset_n),
      .push    (bus.wr_en),
      .pop     (fifo_pop),
      .wdata   (bus.wr_data),
      .rdata   (fifo_rdata),
      .full    (bus.fifo_full),
      .empty   (fifo_empty),
      .count   (bus.fifo_count),
      .overflow(bus.overflow)
   );

   assign cfg_parity = parity_e'(bus.parity_type);
   assign bit_end    = (baud_q == BAUD_LAST);
   assign can_load   = bus.send && !fifo_empty;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      baud_d     = baud_q;
      idx_d      = idx_q;
      stop_cnt_d = stop_cnt_q;
      par_type_d = par_type_q;
      stop2_d    = stop2_q;
      par_bit_d  = par_bit_q;
      done_d     = 1'b0;
      load       = 1'b0;
      fifo_pop   = 1'b0;

      if (state_q != IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            load = can_load;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d    = parity_en(par_type_q) ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                  load    = can_load;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Config is sampled only here, so mid-frame changes wait for the next frame.
      if (load) begin
         fifo_pop   = 1'b1;
         state_d    = START;
         shift_d    = fifo_rdata;
         baud_d     = '0;
         idx_d      = '0;
         par_type_d = cfg_parity;
         stop2_d    = bus.stop_bits;
         par_bit_d  = parity_bit(^fifo_rdata, cfg_parity);
      end
   end

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         baud_q     <= '0;
         idx_q      <= '0;
         stop_cnt_q <= 1'b0;
         par_type_q <= PAR_NONE;
         stop2_q    <= 1'b0;
         par_bit_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         idx_q      <= idx_d;
         stop_cnt_q <= stop_cnt_d;
         par_type_q <= par_type_d;
         stop2_q    <= stop2_d;
         par_bit_q  <= par_bit_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      tx_bit = 1'b1;
      unique case (state_q)
         START:   tx_bit = 1'b0;
         DATA:    tx_bit = shift_q[0];
         PARITY:  tx_bit = par_bit_q;
         default: tx_bit = 1'b1;
      endcase
   end

   assign bus.data_tx     = tx_bit;
   assign bus.active_flag = (state_q != IDLE);
   assign bus.done_flag   = done_q;
   assign bus.fifo_empty  = fifo_empty;

endmodule

// File: tb/tb_uart_piso_tx.sv
// Directed bench for uart_piso_tx: one-bit-per-clock instance plus a four-clocks-per-bit instance.
module tb_uart_piso_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   uart_piso_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
   uart_piso_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_b ();

   uart_piso_tx #(
      .DATA_BITS   (8),
      .FIFO_DEPTH  (4),
      .CLKS_PER_BIT(1)
   ) u_dut (
      .baud_clk(clk),
      .reset_n (rst_n),
      .bus     (bus_a)
   );

   uart_piso_tx #(
      .DATA_BITS   (8),
      .FIFO_DEPTH  (4),
      .CLKS_PER_BIT(4)
   ) u_dut4 (
      .baud_clk(clk),
      .reset_n (rst_n),
      .bus     (bus_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write one byte with send already high; returns at the sample point of the start bit.
   task automatic write_and_start(input logic [7:0] d);
      bus_a.wr_data = d;
      bus_a.wr_en   = 1'b1;
      tick();
      bus_a.wr_en = 1'b0;
      tick();
   endtask

   // bits[0] is the start bit; expects the FIFO to be empty once the frame ends.
   task automatic check_frame(input string tag, input logic [15:0] bits, input int len);
      for (int i = 0; i < len; i++) begin
         check(tag, bus_a.data_tx, bits[i]);
         check({tag, "_nodone"}, bus_a.done_flag, 1'b0);
         tick();
      end
      check({tag, "_done"}, bus_a.done_flag, 1'b1);
      check({tag, "_idle"}, bus_a.active_flag, 1'b0);
      tick();
      check({tag, "_done_pulse"}, bus_a.done_flag, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q3 [4];
      logic [9:0] f10;
      logic [10:0] fa;

      q3 = '{8'h01, 8'h80, 8'hC3, 8'h5A};
      bus_a.send = 1'b0; bus_a.parity_type = 2'b00; bus_a.stop_bits = 1'b0;
      bus_a.wr_en = 1'b0; bus_a.wr_data = '0;
      bus_b.send = 1'b0; bus_b.parity_type = 2'b00; bus_b.stop_bits = 1'b0;
      bus_b.wr_en = 1'b0; bus_b.wr_data = '0;

      // Reset state
      #2 rst_n = 1'b0;
      #2;
      check("rst_tx", bus_a.data_tx, 1'b1);
      check("rst_active", bus_a.active_flag, 1'b0);
      check("rst_done", bus_a.done_flag, 1'b0);
      check("rst_ovf", bus_a.overflow, 1'b0);
      check("rst_empty", bus_a.fifo_empty, 1'b1);
      check("rst_full", bus_a.fifo_full, 1'b0);
      check("rst_count", bus_a.fifo_count, 0);
      #8 rst_n = 1'b1;
      tick();

      // 1: 8'h4A, even parity, one stop
      bus_a.parity_type = 2'b10;
      bus_a.send        = 1'b1;
      bus_a.wr_data     = 8'h4A;
      bus_a.wr_en       = 1'b1;
      tick();
      bus_a.wr_en = 1'b0;
      check("t1_pre_tx", bus_a.data_tx, 1'b1);
      check("t1_pre_count", bus_a.fifo_count, 1);
      check("t1_pre_empty", bus_a.fifo_empty, 1'b0);
      tick();
      check("t1_active", bus_a.active_flag, 1'b1);
      check("t1_count", bus_a.fifo_count, 0);
      check_frame("t1_bit", 16'(11'b1_1_01001010_0), 11);

      // 2: odd parity, then no parity
      bus_a.parity_type = 2'b01;
      write_and_start(8'h4A);
      check_frame("t2_odd", 16'(11'b1_0_01001010_0), 11);
      bus_a.parity_type = 2'b00;
      write_and_start(8'h4A);
      check_frame("t2_none", 16'(10'b1_01001010_0), 10);

      // 3: fill while send=0, overflow, then four back-to-back frames
      bus_a.send  = 1'b0;
      bus_a.wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_a.wr_data = q3[i];
         tick();
      end
      check("t3_full", bus_a.fifo_full, 1'b1);
      check("t3_count4", bus_a.fifo_count, 4);
      check("t3_noovf", bus_a.overflow, 1'b0);
      check("t3_idle", bus_a.active_flag, 1'b0);
      bus_a.wr_data = 8'hEE;
      tick();
      bus_a.wr_en = 1'b0;
      check("t3_ovf", bus_a.overflow, 1'b1);
      check("t3_count_after", bus_a.fifo_count, 4);
      tick();
      check("t3_ovf_pulse", bus_a.overflow, 1'b0);
      bus_a.send = 1'b1;
      tick();
      check("t3_count3", bus_a.fifo_count, 3);
      for (int j = 0; j < 4; j++) begin
         f10 = {1'b1, q3[j], 1'b0};
         for (int i = 0; i < 10; i++) begin
            check("t3_bit", bus_a.data_tx, f10[i]);
            check("t3_active", bus_a.active_flag, 1'b1);
            check("t3_done", bus_a.done_flag, (i == 0 && j > 0) ? 1'b1 : 1'b0);
            tick();
         end
      end
      check("t3_last_done", bus_a.done_flag, 1'b1);
      check("t3_end_idle", bus_a.active_flag, 1'b0);
      check("t3_end_empty", bus_a.fifo_empty, 1'b1);
      check("t3_end_tx", bus_a.data_tx, 1'b1);
      tick();

      // 4: four clocks per bit, two stop bits, 8'hFF, no parity
      bus_b.stop_bits = 1'b1;
      bus_b.send      = 1'b1;
      bus_b.wr_data   = 8'hFF;
      bus_b.wr_en     = 1'b1;
      tick();
      bus_b.wr_en = 1'b0;
      tick();
      for (int i = 0; i < 44; i++) begin
         check("t4_bit", bus_b.data_tx, (i < 4) ? 1'b0 : 1'b1);
         check("t4_nodone", bus_b.done_flag, 1'b0);
         check("t4_active", bus_b.active_flag, 1'b1);
         tick();
      end
      check("t4_done", bus_b.done_flag, 1'b1);
      check("t4_idle", bus_b.active_flag, 1'b0);
      tick();

      // 5: asynchronous reset in the middle of DATA
      bus_a.stop_bits = 1'b0;
      bus_a.wr_data   = 8'h55;
      bus_a.wr_en     = 1'b1;
      tick();
      bus_a.wr_data = 8'h33;
      tick();
      bus_a.wr_en = 1'b0;
      tick();
      tick();
      check("t5_mid_tx", bus_a.data_tx, 1'b0);
      check("t5_mid_count", bus_a.fifo_count, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_tx", bus_a.data_tx, 1'b1);
      check("t5_rst_active", bus_a.active_flag, 1'b0);
      check("t5_rst_empty", bus_a.fifo_empty, 1'b1);
      check("t5_rst_count", bus_a.fifo_count, 0);
      check("t5_rst_full", bus_a.fifo_full, 1'b0);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_nodone", bus_a.done_flag, 1'b0);
         check("t5_idle_tx", bus_a.data_tx, 1'b1);
      end

      // 6: config/send changes mid-frame only affect the next frame
      bus_a.parity_type = 2'b10;
      bus_a.stop_bits   = 1'b0;
      bus_a.wr_data     = 8'h0F;
      bus_a.wr_en       = 1'b1;
      tick();
      bus_a.wr_data = 8'hF0;
      tick();
      bus_a.wr_en = 1'b0;
      check("t6_count", bus_a.fifo_count, 1);
      fa = 11'b1_0_00001111_0;
      for (int i = 0; i < 11; i++) begin
         check("t6_bit", bus_a.data_tx, fa[i]);
         if (i == 3) begin
            bus_a.parity_type = 2'b00;
            bus_a.stop_bits   = 1'b1;
            bus_a.send        = 1'b0;
         end
         tick();
      end
      check("t6_done", bus_a.done_flag, 1'b1);
      check("t6_idle", bus_a.active_flag, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_held_tx", bus_a.data_tx, 1'b1);
         check("t6_held_idle", bus_a.active_flag, 1'b0);
         check("t6_queued", bus_a.fifo_count, 1);
      end
      bus_a.send = 1'b1;
      tick();
      check_frame("t6_next", 16'(11'b11_11110000_0), 11);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
